// File: rtl/matrix_mac_sequencer_if.sv
// Operand/accumulator and result-writer signals shared by the MAC sequencer
// (master) and the datapath/storage it drives (slave).
interface matrix_mac_sequencer_if #(
    parameter int M_SIZE = 4
);
    localparam int IDX_W = $clog2(M_SIZE);

    logic               operand_valid;
    logic               acc_clear;
    logic               acc_enable;
    logic [2*IDX_W-1:0] a_addr;
    logic [2*IDX_W-1:0] b_addr;
    logic               c_valid;
    logic               c_ready;
    logic [2*IDX_W-1:0] c_addr;

    modport master (
        input  operand_valid,
        input  c_ready,
        output acc_clear,
        output acc_enable,
        output a_addr,
        output b_addr,
        output c_valid,
        output c_addr
    );

    modport slave (
        output operand_valid,
        output c_ready,
        input  acc_clear,
        input  acc_enable,
        input  a_addr,
        input  b_addr,
        input  c_valid,
        input  c_addr
    );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Sequences one M_SIZE x M_SIZE multiply C = A*B through a shared accumulator.
// Optional cancel of an in-flight multiply: define MAC_SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, counters zero
// CLEAR | one-cycle accumulator clear before each element
// ACCUM | stepping k with operand_valid, one product per valid cycle
// WRITE | presenting finished element until the writer accepts it
// DONE  | one-cycle completion pulse, counters zero
module matrix_mac_sequencer #(
    parameter int M_SIZE = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         busy,
    output logic                         done,
    matrix_mac_sequencer_if.master       mac
);
    localparam int IDX_W = $clog2(M_SIZE);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(M_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clear_q, clear_d;
    logic               c_valid_q, c_valid_d;
    logic [2*IDX_W-1:0] a_addr_q, a_addr_d;
    logic [2*IDX_W-1:0] b_addr_q, b_addr_d;
    logic [2*IDX_W-1:0] c_addr_q, c_addr_d;
`ifdef MAC_SEQ_ABORT_EN
    logic               abort_hit;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
`ifdef MAC_SEQ_ABORT_EN
        abort_hit = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (start) state_d = CLEAR;
            end
            CLEAR: state_d = ACCUM;
            ACCUM: begin
                if (mac.operand_valid) begin
                    if (k_q == IDX_MAX) begin
                        k_d     = '0;
                        state_d = WRITE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mac.c_ready) begin
                    if (i_q == IDX_MAX && j_q == IDX_MAX) begin
                        // zero here so DONE already shows idle counters/addresses
                        i_d     = '0;
                        j_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CLEAR;
                        if (j_q == IDX_MAX) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MAC_SEQ_ABORT_EN
        if (abort && (state_q inside {CLEAR, ACCUM, WRITE})) begin
            abort_hit = 1'b1;
            state_d   = IDLE;
            i_d       = '0;
            j_d       = '0;
            k_d       = '0;
        end
`endif
        // outputs are registered from the next state so they line up with it
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        clear_d   = (state_d == CLEAR);
        c_valid_d = (state_d == WRITE);
        a_addr_d  = {i_d, k_d};
        b_addr_d  = {k_d, j_d};
        c_addr_d  = {i_d, j_d};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clear_q   <= 1'b0;
            c_valid_q <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clear_q   <= clear_d;
            c_valid_q <= c_valid_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            c_addr_q  <= c_addr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mac.acc_enable = (state_q == ACCUM) && mac.operand_valid;
`ifdef MAC_SEQ_ABORT_EN
    // clearing on abort leaves the accumulator empty for the next run
    assign mac.acc_clear  = clear_q | abort_hit;
`else
    assign mac.acc_clear  = clear_q;
`endif
    assign mac.a_addr     = a_addr_q;
    assign mac.b_addr     = b_addr_q;
    assign mac.c_valid    = c_valid_q;
    assign mac.c_addr     = c_addr_q;
endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed self-checking bench for matrix_mac_sequencer at M_SIZE=4.
module tb_matrix_mac_sequencer;
    localparam int M = 4;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef MAC_SEQ_ABORT_EN
    logic abort;
`endif

    int checks   = 0;
    int failures = 0;

    int r_done_cyc, r_done_cnt, r_busy_first, r_busy_last, r_busy_cnt, r_busy_after;
    int r_valid_cnt, r_accepts, r_addr_err, r_clear_cnt, r_en_cnt, r_clr_en;
    int r_stall_err, r_bp_err, r_log_n;
    logic [3:0] r_a_log [4];
    logic [3:0] r_b_log [4];

    matrix_mac_sequencer_if #(.M_SIZE(M)) mac ();

    matrix_mac_sequencer #(.M_SIZE(M)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
`ifdef MAC_SEQ_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .mac   (mac)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        mac.operand_valid = 1'b1;
        mac.c_ready = 1'b1;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Runs one multiply from IDLE; cycle n is the period sampled by edge n
    // (start is sampled at edge 0). Stall/backpressure windows are placed at
    // their undisturbed timing: element e has CLEAR at 1+6e, k=2 at 4+6e, WRITE at 6+6e.
    task automatic run_multiply(input int stall_elem, input int stall_len,
                                input int bp_elem, input int bp_len,
                                input int extra_start, input bit b2b, input int mon_elem);
        int n, stall_at, bp_at;
        bit stop, in_stall, in_bp;
        logic [3:0] exp_a, exp_b;
        stall_at = 1 + stall_elem * (M + 2) + 3;
        bp_at    = 1 + bp_elem * (M + 2) + 5;
        exp_a    = 4'((stall_elem / M) * M + 2);
        exp_b    = 4'(2 * M + stall_elem % M);
        r_done_cyc = -1; r_done_cnt = 0; r_busy_first = -1; r_busy_last = -1;
        r_busy_cnt = 0; r_busy_after = -1; r_valid_cnt = 0; r_accepts = 0;
        r_addr_err = 0; r_clear_cnt = 0; r_en_cnt = 0; r_clr_en = -1;
        r_stall_err = 0; r_bp_err = 0; r_log_n = 0;
        n = 0;
        stop = 1'b0;
        while (!stop && n < 300) begin
            in_stall = (stall_len > 0) && (n >= stall_at) && (n < stall_at + stall_len);
            in_bp    = (bp_len > 0) && (n >= bp_at) && (n < bp_at + bp_len);
            start = (n == 0) || (n == extra_start) ||
                    (b2b && r_done_cyc >= 0 && n == r_done_cyc + 1);
            mac.operand_valid = !in_stall;
            mac.c_ready = !in_bp;
            @(negedge clock);
            if (busy) begin
                if (r_busy_first < 0) r_busy_first = n;
                r_busy_last = n;
                r_busy_cnt++;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = n;
            end
            if (mac.acc_clear) begin
                r_clear_cnt++;
                if (r_accepts == mon_elem) r_clr_en = int'(mac.acc_enable);
            end
            if (mac.acc_enable && r_accepts == mon_elem) begin
                r_en_cnt++;
                if (r_log_n < 4) begin
                    r_a_log[r_log_n] = mac.a_addr;
                    r_b_log[r_log_n] = mac.b_addr;
                    r_log_n++;
                end
            end
            if (in_stall && (mac.acc_enable !== 1'b0 || mac.a_addr !== exp_a || mac.b_addr !== exp_b))
                r_stall_err++;
            if (in_bp && (mac.c_valid !== 1'b1 || mac.c_addr !== 4'(bp_elem) || mac.acc_clear !== 1'b0))
                r_bp_err++;
            if (mac.c_valid) begin
                r_valid_cnt++;
                if (mac.c_addr !== 4'(r_accepts)) r_addr_err++;
                if (mac.c_ready) r_accepts++;
            end
            stop = (r_done_cyc >= 0 && n == r_done_cyc + 1);
            if (stop) r_busy_after = int'(busy);
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        mac.operand_valid = 1'b1;
        mac.c_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        mac.operand_valid = 1'b1;
        mac.c_ready = 1'b1;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, done, mac.acc_clear, mac.acc_enable, mac.c_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy, done, mac.acc_clear, mac.acc_enable, mac.c_valid});
        end
        checks++;
        if ({mac.a_addr, mac.b_addr, mac.c_addr} !== 12'h000) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 000", {mac.a_addr, mac.b_addr, mac.c_addr});
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_free_run();
        do_reset();
        run_multiply(0, 0, 0, 0, -1, 1'b0, 99);
        checks++; if (r_done_cyc !== 97) begin failures++; $display("FAIL free_done_cycle: got %0d expected 97", r_done_cyc); end
        checks++; if (r_done_cnt !== 1) begin failures++; $display("FAIL free_done_count: got %0d expected 1", r_done_cnt); end
        checks++; if (r_busy_first !== 1) begin failures++; $display("FAIL free_busy_first: got %0d expected 1", r_busy_first); end
        checks++; if (r_busy_cnt !== 97) begin failures++; $display("FAIL free_busy_cycles: got %0d expected 97", r_busy_cnt); end
        checks++; if (r_busy_after !== 0) begin failures++; $display("FAIL free_busy_fall: got %0d expected 0", r_busy_after); end
        checks++; if (r_valid_cnt !== 16) begin failures++; $display("FAIL free_valid_cycles: got %0d expected 16", r_valid_cnt); end
        checks++; if (r_addr_err !== 0) begin failures++; $display("FAIL free_c_addr_order: got %0d errors expected 0", r_addr_err); end
        checks++; if (r_clear_cnt !== 16) begin failures++; $display("FAIL free_clear_count: got %0d expected 16", r_clear_cnt); end
    endtask

    task automatic test_address_seq();
        do_reset();
        run_multiply(0, 0, 0, 0, -1, 1'b0, 9);
        checks++; if (r_clr_en !== 0) begin failures++; $display("FAIL addr_clear_enable: got %0d expected 0", r_clr_en); end
        checks++; if (r_en_cnt !== 4) begin failures++; $display("FAIL addr_enable_count: got %0d expected 4", r_en_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (r_a_log[k] !== 4'(8 + k) || r_b_log[k] !== 4'(1 + 4 * k)) begin
                failures++;
                $display("FAIL addr_k%0d: got a=%0d b=%0d expected a=%0d b=%0d",
                         k, r_a_log[k], r_b_log[k], 8 + k, 1 + 4 * k);
            end
        end
    endtask

    task automatic test_operand_stall();
        do_reset();
        run_multiply(5, 3, 0, 0, -1, 1'b0, 5);
        checks++; if (r_stall_err !== 0) begin failures++; $display("FAIL stall_hold: got %0d errors expected 0", r_stall_err); end
        checks++; if (r_en_cnt !== 4) begin failures++; $display("FAIL stall_enable_count: got %0d expected 4", r_en_cnt); end
        checks++; if (r_done_cyc !== 100) begin failures++; $display("FAIL stall_done_cycle: got %0d expected 100", r_done_cyc); end
        checks++; if (r_addr_err !== 0) begin failures++; $display("FAIL stall_c_addr_order: got %0d errors expected 0", r_addr_err); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_multiply(0, 0, 7, 5, -1, 1'b0, 99);
        checks++; if (r_bp_err !== 0) begin failures++; $display("FAIL bp_hold: got %0d errors expected 0", r_bp_err); end
        checks++; if (r_valid_cnt !== 21) begin failures++; $display("FAIL bp_valid_cycles: got %0d expected 21", r_valid_cnt); end
        checks++; if (r_accepts !== 16) begin failures++; $display("FAIL bp_accepts: got %0d expected 16", r_accepts); end
        checks++; if (r_done_cyc !== 102) begin failures++; $display("FAIL bp_done_cycle: got %0d expected 102", r_done_cyc); end
    endtask

    task automatic test_reset_restart();
        do_reset();
        for (int n = 0; n < 36; n++) begin
            start = (n == 0);
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (mac.c_valid !== 1'b1 || mac.c_addr !== 4'd5) begin
            failures++;
            $display("FAIL rst_mid_write: got valid=%b addr=%0d expected valid=1 addr=5", mac.c_valid, mac.c_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, mac.acc_clear, mac.acc_enable, mac.c_valid, mac.a_addr, mac.b_addr, mac.c_addr} !== 17'h0) begin
            failures++;
            $display("FAIL rst_async_outputs: got %h expected 0",
                     {busy, done, mac.acc_clear, mac.acc_enable, mac.c_valid, mac.a_addr, mac.b_addr, mac.c_addr});
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_multiply(0, 0, 0, 0, -1, 1'b0, 99);
        checks++; if (r_done_cyc !== 97) begin failures++; $display("FAIL rst_restart_done: got %0d expected 97", r_done_cyc); end
        checks++; if (r_accepts !== 16 || r_addr_err !== 0) begin failures++; $display("FAIL rst_restart_elems: got %0d accepts %0d errors expected 16 and 0", r_accepts, r_addr_err); end
    endtask

    task automatic test_busy_start_ignored();
        do_reset();
        run_multiply(0, 0, 0, 0, 50, 1'b0, 99);
        checks++; if (r_done_cyc !== 97 || r_accepts !== 16) begin failures++; $display("FAIL busy_start_mid: got done=%0d accepts=%0d expected 97 and 16", r_done_cyc, r_accepts); end
        do_reset();
        run_multiply(0, 0, 0, 0, 97, 1'b0, 99);
        checks++; if (r_busy_after !== 0) begin failures++; $display("FAIL busy_start_in_done: got busy=%0d expected 0", r_busy_after); end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_in_done_idle: got %b expected 0", busy); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_multiply(0, 0, 0, 0, -1, 1'b1, 99);
        checks++; if (r_done_cyc !== 97) begin failures++; $display("FAIL b2b_first_done: got %0d expected 97", r_done_cyc); end
        @(negedge clock);
        checks++;
        if (mac.acc_clear !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_clear: got clear=%b busy=%b expected 1 1", mac.acc_clear, busy);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (mac.acc_enable !== 1'b1 || mac.a_addr !== 4'd0 || mac.b_addr !== 4'd0) begin
            failures++;
            $display("FAIL b2b_accum: got en=%b a=%0d b=%0d expected 1 0 0", mac.acc_enable, mac.a_addr, mac.b_addr);
        end
        @(posedge clock);
        #1;
    endtask

`ifdef MAC_SEQ_ABORT_EN
    task automatic test_abort();
        int dones;
        do_reset();
        for (int n = 0; n < 21; n++) begin
            start = (n == 0);
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        checks++;
        if (mac.acc_clear !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_clear: got clear=%b busy=%b expected 1 1", mac.acc_clear, busy);
        end
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || mac.acc_clear !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b clear=%b expected 0 0", busy, mac.acc_clear);
        end
        dones = int'(done);
        repeat (5) begin
            @(negedge clock);
            dones += int'(done);
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        @(posedge clock);
        #1;
        run_multiply(0, 0, 0, 0, -1, 1'b0, 99);
        checks++; if (r_addr_err !== 0 || r_accepts !== 16) begin failures++; $display("FAIL abort_restart: got %0d errors %0d accepts expected 0 and 16", r_addr_err, r_accepts); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mac.operand_valid = 1'b0;
        mac.c_ready = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_free_run();
        test_address_seq();
        test_operand_stall();
        test_backpressure();
        test_reset_restart();
        test_busy_start_ignored();
        test_back_to_back();
`ifdef MAC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
